// File: rtl/mdu_pkg.sv
// Purpose : shared encodings and helpers for the iterative multiply/divide unit.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: op encodings, FSM state encoding, step count, conditional-negate helper.
// Config  : MUL_DIV_UNIT_DIV_EN selects whether the divider datapath is built.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_SIGN = 2'b10
   } mdu_state_e;

   localparam int MDU_STEPS = 32;
   localparam int MDU_CNT_W = 5;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [31:0] mdu_cneg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Purpose : one iteration of the multiply (shift-add) or divide (restoring) datapath.
// Latency : purely combinational, zero cycles.
// Backpres: none; the caller decides when to register acc_nxt.
// Ports   : acc      - 64-bit accumulator {upper, lower} from the previous step
//           opnd     - multiplicand (multiply) or divisor (divide), unsigned magnitude
//           is_div   - selects the divide step (only meaningful with MUL_DIV_UNIT_DIV_EN)
//           acc_nxt  - accumulator value after this step
// Config  : MUL_DIV_UNIT_DIV_EN builds the restoring-divide step; otherwise multiply only.
module mdu_iter
   import mdu_pkg::*;
(
   input  logic [63:0] acc,
   input  logic [31:0] opnd,
   input  logic        is_div,
   output logic [63:0] acc_nxt
);

   // Multiply: acc = {partial product, remaining multiplier bits}. Add the
   // multiplicand into the upper half when the current multiplier LSB is set,
   // then shift the whole thing right, keeping the carry out of the add.
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;

   always_comb begin
      mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_nxt = {mul_sum, acc[31:1]};
   end

`ifdef MUL_DIV_UNIT_DIV_EN
   // Divide: acc = {partial remainder, dividend bits / quotient bits}.
   // Shift left by one, try subtracting the divisor from the 33-bit shifted
   // remainder, keep the difference and shift in a 1 if it does not go negative.
   // The difference is always below the divisor, so 32 bits hold it exactly.
   logic [32:0] rem_sh;
   logic [31:0] diff;
   logic        fits;
   logic [63:0] div_nxt;

   always_comb begin
      rem_sh  = acc[63:31];
      diff    = rem_sh[31:0] - opnd;
      fits    = (rem_sh >= {1'b0, opnd});
      div_nxt = {(fits ? diff : rem_sh[31:0]), acc[30:0], fits};
   end

   assign acc_nxt = is_div ? div_nxt : mul_nxt;
`else
   logic unused_is_div;
   assign unused_is_div = is_div;
   assign acc_nxt       = mul_nxt;
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Purpose : iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Latency : start at edge E -> HI/LO written at E+33, done high the following cycle.
// Backpres: busy high while an op is in flight; start while busy is dropped, not queued.
// Ports   : clk, clrn (async active-low) ; a, b operands ; start, op issue request ;
//           wr_hi, wr_lo, wd MTHI/MTLO ; hi, lo registers ; busy, done status.
// Config  : MUL_DIV_UNIT_DIV_EN builds the divider; without it DIV/DIVU complete in
//           one busy cycle and leave HI/LO untouched.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wd,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   mdu_state_e           state;
   mdu_state_e           state_nxt;
   logic [MDU_CNT_W-1:0] cnt;
   logic [63:0]          acc;
   logic [63:0]          acc_nxt;
   logic [31:0]          opnd;
   logic                 is_div;
   logic                 res_neg;

   logic                 op_div;
   logic                 op_signed;
   logic [31:0]          a_abs;
   logic [31:0]          b_abs;
   logic                 last_step;

   logic                 res_wr;
   logic [31:0]          res_hi;
   logic [31:0]          res_lo;
   logic [63:0]          prod_fix;

`ifdef MUL_DIV_UNIT_DIV_EN
   logic                 rem_neg;
`endif

   // ---------------------------------------------------------------------
   // Operand decode
   // ---------------------------------------------------------------------
   always_comb begin
      op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
      op_signed = (op == MDU_MULT) || (op == MDU_DIV);
      a_abs     = mdu_cneg(a, op_signed & a[31]);
      b_abs     = mdu_cneg(b, op_signed & b[31]);
   end

   assign last_step = (state == ST_CALC) && (cnt == MDU_CNT_W'(MDU_STEPS - 1));
   assign busy      = (state != ST_IDLE);

   mdu_iter u_iter (
      .acc     (acc),
      .opnd    (opnd),
      .is_div  (is_div),
      .acc_nxt (acc_nxt)
   );

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
`ifdef MUL_DIV_UNIT_DIV_EN
               state_nxt = ST_CALC;
`else
               // No divider: a divide issue just passes through SIGN so the
               // pipeline still sees busy/done, without touching HI/LO.
               state_nxt = op_div ? ST_SIGN : ST_CALC;
`endif
            end
         end
         ST_CALC: begin
            if (last_step) begin
               state_nxt = ST_SIGN;
            end
         end
         ST_SIGN: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Sign fixup and result selection (only acted on in SIGN)
   // ---------------------------------------------------------------------
   always_comb begin
      res_wr   = 1'b0;
      res_hi   = hi;
      res_lo   = lo;
      prod_fix = res_neg ? (~acc + 64'd1) : acc;
      if (state == ST_SIGN) begin
         if (!is_div) begin
            res_wr = 1'b1;
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
         end
`ifdef MUL_DIV_UNIT_DIV_EN
         else begin
            // Divide by zero leaves quotient all ones and remainder |a|;
            // res_neg is held clear for b==0 and the remainder takes the
            // dividend's sign, so hi ends up equal to the original a.
            res_wr = 1'b1;
            res_hi = mdu_cneg(acc[63:32], rem_neg);
            res_lo = mdu_cneg(acc[31:0], res_neg);
         end
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Datapath and HI/LO registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         res_neg <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
         rem_neg <= 1'b0;
`endif
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == ST_SIGN);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  is_div  <= op_div;
                  // Quotient sign excludes b==0 so the forced all-ones
                  // divide-by-zero quotient is never negated.
                  res_neg <= op_signed & (a[31] ^ b[31]) & ~(op_div & (b == 32'd0));
`ifdef MUL_DIV_UNIT_DIV_EN
                  rem_neg <= op_signed & a[31];
`endif
                  if (op_div) begin
                     acc  <= {32'd0, a_abs};
                     opnd <= b_abs;
                  end else begin
                     acc  <= {32'd0, b_abs};
                     opnd <= a_abs;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
            end
            default: begin
            end
         endcase

         // A computed result has priority; MTHI/MTLO are dropped in SIGN.
         if (res_wr) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state != ST_SIGN) begin
            if (wr_hi) begin
               hi <= wd;
            end
            if (wr_lo) begin
               lo <= wd;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose : directed-vector scoreboard bench for mul_div_unit.
// Latency : expects HI/LO 33 edges after start, done one cycle later.
// Backpres: drives start only when idle, except for the deliberate ignored-start case.
module tb_mul_div_unit;

`ifdef MUL_DIV_UNIT_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk   = 1'b0;
   logic        clrn  = 1'b1;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        start = 1'b0;
   logic [1:0]  op    = '0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wd    = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        prev_done = 1'b0;
   logic [63:0] mon_e;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk   (clk),
      .clrn  (clrn),
      .a     (a),
      .b     (b),
      .start (start),
      .op    (op),
      .wr_hi (wr_hi),
      .wr_lo (wr_lo),
      .wd    (wd),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: every done pulse pops the oldest expected {hi,lo}.
   always @(negedge clk) begin
      if (clrn && done) begin
         chk("done_single_cycle", 64'(prev_done), 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_hi", 64'(hi), 64'(mon_e[63:32]));
            chk("result_lo", 64'(lo), 64'(mon_e[31:0]));
         end
      end
      prev_done = done;
   end

   // Issue one op, push its expected result, and track busy length and
   // HI/LO hold. restart_at>0 pulses a second start on that busy cycle;
   // mthi_sign drives MTHI on the SIGN edge; mtlo_start drives MTLO with start.
   task automatic issue(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int restart_at, input bit mthi_sign, input bit mtlo_start);
      int          exp_busy;
      int          n;
      bit          hold_ok;
      logic [31:0] rh;
      logic [31:0] rl;
      exp_busy = 33;
      op    = o;
      a     = xa;
      b     = xb;
      start = 1'b1;
      if (mtlo_start) begin
         wr_lo = 1'b1;
         wd    = 32'h5555_AAAA;
         m_lo  = 32'h5555_AAAA;
      end
      rh = ehi;
      rl = elo;
      if (o[1] && !DIV_EN) begin
         rh       = m_hi;
         rl       = m_lo;
         exp_busy = 1;
      end
      exp_q.push_back({rh, rl});
      @(negedge clk);
      start   = 1'b0;
      wr_lo   = 1'b0;
      n       = 0;
      hold_ok = 1'b1;
      while (busy && n < 100) begin
         n++;
         if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
         if (n == restart_at) begin
            start = 1'b1;
            op    = OP_MULT;
            a     = 32'd1000;
            b     = 32'd3;
         end
         if (mthi_sign && n == exp_busy) begin
            wr_hi = 1'b1;
            wd    = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         start = 1'b0;
         wr_hi = 1'b0;
      end
      chk("busy_cycles", 64'(n), 64'(exp_busy));
      chk("hold_during_calc", 64'(hold_ok), 64'd1);
      m_hi = rh;
      m_lo = rl;
   endtask

   initial begin
      int w;
      #2 clrn = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      clrn = 1'b1;
      @(negedge clk);

      // Multiplies
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0);
      issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0);
      issue(OP_MULT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, 0, 0, 0);
      issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 0, 0);

      // Divides (hi = remainder, lo = quotient)
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0);
      issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0, 0);
      issue(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 0, 0, 0);
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, 0);
      issue(OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 0, 0, 0);
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0, 0);

      // Second start at E+5 is ignored
      issue(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 5, 0, 0);

      // MTLO / MTHI while idle
      wr_lo = 1'b1;
      wd    = 32'h0000_1234;
      @(negedge clk);
      wr_lo = 1'b0;
      m_lo  = 32'h0000_1234;
      chk("mtlo_idle", 64'(lo), 64'h1234);
      wr_hi = 1'b1;
      wd    = 32'h0000_ABCD;
      @(negedge clk);
      wr_hi = 1'b0;
      m_hi  = 32'h0000_ABCD;
      chk("mthi_idle", 64'(hi), 64'hABCD);

      // MTHI on the SIGN edge loses to the result
      issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 0, 1, 0);
      // MTLO together with start: applied, then overwritten by the result
      issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'h0000_0006, 0, 0, 1);

      // Reset in the middle of an operation
      op    = OP_MULTU;
      a     = 32'hFFFF_FFFF;
      b     = 32'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("busy_before_abort", 64'(busy), 64'd1);
      clrn = 1'b0;
      #1;
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      clrn = 1'b1;
      m_hi = '0;
      m_lo = '0;
      repeat (50) @(negedge clk);
      chk("post_abort_busy", 64'(busy), 64'd0);
      chk("post_abort_lo", 64'(lo), 64'd0);

      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
